// File: rtl/mac_cmd_rx.sv
// Host command receiver feeding the NxN MAC systolic-array FSM.
// Parses header+payload byte frames into registered data_v/mode/rst_addr/data strobes.
module mac_cmd_rx #(
    parameter int N     = 2,
    parameter int NN    = N * N,
    parameter int W     = 8,
    parameter int LEN_W = W - 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         data_v_o,
    output logic         data_mode_o,
    output logic         data_rst_addr_o,
    output logic [W-1:0] data_o,
    output logic         busy_o,
    output logic         err_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [1:0] OP_DATA    = 2'b00;
    localparam logic [1:0] OP_WEIGHT  = 2'b01;
    localparam logic [1:0] OP_RSTADDR = 2'b10;

    localparam logic [LEN_W:0] ONE_L = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] NN_L  = NN[LEN_W:0];

    state_t         state_r, state_next_s;
    logic [LEN_W:0] remaining_r, remaining_next_s;
    logic [LEN_W:0] widx_r, widx_next_s;
    logic           mode_r, mode_next_s;
    logic           err_r, err_next_s;

    logic           data_v_r, data_v_next_s;
    logic           data_mode_r, data_mode_next_s;
    logic           data_rst_addr_r, data_rst_addr_next_s;
    logic [W-1:0]   data_r, data_next_s;
    logic           busy_r;

    logic           accept_s;
    logic [1:0]     op_s;
    logic [LEN_W:0] len_plus1_s;

    assign in_ready_o  = ena;
    assign accept_s    = in_valid_i & ena;
    assign op_s        = in_data_i[W-1:W-2];
    assign len_plus1_s = {1'b0, in_data_i[LEN_W-1:0]} + ONE_L;

    // Frame decode, weight policing and next output values
    always_comb begin
        state_next_s         = state_r;
        remaining_next_s     = remaining_r;
        widx_next_s          = widx_r;
        mode_next_s          = mode_r;
        err_next_s           = err_r;
        data_v_next_s        = 1'b0;
        data_rst_addr_next_s = 1'b0;
        data_mode_next_s     = data_mode_r;
        data_next_s          = data_r;

        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    case (op_s)
                        OP_DATA: begin
                            state_next_s     = PAYLOAD;
                            remaining_next_s = len_plus1_s;
                            mode_next_s      = 1'b0;
                        end
                        OP_WEIGHT: begin
                            state_next_s     = PAYLOAD;
                            remaining_next_s = len_plus1_s;
                            mode_next_s      = 1'b1;
                            widx_next_s      = {(LEN_W+1){1'b0}};
                        end
                        OP_RSTADDR: begin
                            data_v_next_s        = 1'b1;
                            data_rst_addr_next_s = 1'b1;
                            data_mode_next_s     = 1'b0;
                            data_next_s          = {W{1'b0}};
                            err_next_s           = 1'b0;
                        end
                        default: begin
                            state_next_s = IDLE;
                        end
                    endcase
                end
                PAYLOAD: begin
                    remaining_next_s = remaining_r - ONE_L;
                    if (remaining_r == ONE_L) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = PAYLOAD;
                    end
                    // Weights beyond one full array load are swallowed and flagged
                    if (mode_r && (widx_r >= NN_L)) begin
                        err_next_s = 1'b1;
                    end else begin
                        data_v_next_s    = 1'b1;
                        data_mode_next_s = mode_r;
                        data_next_s      = in_data_i;
                        if (mode_r) begin
                            widx_next_s = widx_r + ONE_L;
                        end else begin
                            widx_next_s = widx_r;
                        end
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            remaining_r     <= {(LEN_W+1){1'b0}};
            widx_r          <= {(LEN_W+1){1'b0}};
            mode_r          <= 1'b0;
            err_r           <= 1'b0;
            data_v_r        <= 1'b0;
            data_mode_r     <= 1'b0;
            data_rst_addr_r <= 1'b0;
            data_r          <= {W{1'b0}};
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            remaining_r     <= remaining_next_s;
            widx_r          <= widx_next_s;
            mode_r          <= mode_next_s;
            err_r           <= err_next_s;
            data_v_r        <= data_v_next_s;
            data_mode_r     <= data_mode_next_s;
            data_rst_addr_r <= data_rst_addr_next_s;
            data_r          <= data_next_s;
            busy_r          <= (state_next_s == PAYLOAD);
        end
    end

    assign data_v_o        = data_v_r;
    assign data_mode_o     = data_mode_r;
    assign data_rst_addr_o = data_rst_addr_r;
    assign data_o          = data_r;
    assign busy_o          = busy_r;
    assign err_o           = err_r;

endmodule

// File: tb/tb_mac_cmd_rx.sv
// Self-checking bench for mac_cmd_rx: hand-derived vector table, directed corner
// sequences and random traffic against a frame-level reference model.
module tb_mac_cmd_rx;

    localparam int N  = 2;
    localparam int NN = N * N;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] in_data_i = 8'h00;
    logic         data_v_o;
    logic         data_mode_o;
    logic         data_rst_addr_o;
    logic [W-1:0] data_o;
    logic         busy_o;
    logic         err_o;

    mac_cmd_rx #(.N(N), .W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .ena             (ena),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .data_v_o        (data_v_o),
        .data_mode_o     (data_mode_o),
        .data_rst_addr_o (data_rst_addr_o),
        .data_o          (data_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: frame-level view of the stream
    bit       m_in_frame;
    int       m_left;
    bit       m_weight;
    int       m_sent;
    bit       m_err;
    bit       exp_v, exp_rst, exp_mode, exp_busy, exp_err;
    bit [7:0] exp_data;

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] d;
        logic       xv;
        logic       xr;
        logic       xm;
        logic [7:0] xd;
        logic       xb;
        logic       xe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic e, logic [7:0] d, logic xv, logic xr,
                                logic xm, logic [7:0] xd, logic xb, logic xe);
        vec_t r;
        r.v = v; r.e = e; r.d = d; r.xv = xv; r.xr = xr;
        r.xm = xm; r.xd = xd; r.xb = xb; r.xe = xe;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_left = 0; m_weight = 0; m_sent = 0; m_err = 0;
        exp_v = 0; exp_rst = 0; exp_mode = 0; exp_busy = 0; exp_err = 0;
        exp_data = 8'h00;
    endtask

    task automatic model_step(input logic v, input logic e, input logic [7:0] d);
        bit [7:0] b;
        b = d;
        exp_v   = 0;
        exp_rst = 0;
        if (v && e) begin
            if (!m_in_frame) begin
                if (b[7:6] == 2'b00 || b[7:6] == 2'b01) begin
                    m_in_frame = 1;
                    m_left     = int'(b[5:0]) + 1;
                    m_weight   = b[6];
                    m_sent     = 0;
                end else if (b[7:6] == 2'b10) begin
                    exp_v = 1; exp_rst = 1; exp_mode = 0; exp_data = 8'h00;
                    m_err = 0;
                end
            end else begin
                m_left = m_left - 1;
                if (m_weight && m_sent >= NN) begin
                    m_err = 1;
                end else begin
                    exp_v = 1; exp_data = b; exp_mode = m_weight;
                    if (m_weight) m_sent = m_sent + 1;
                end
                if (m_left == 0) m_in_frame = 0;
            end
        end
        exp_busy = m_in_frame;
        exp_err  = m_err;
    endtask

    task automatic check_outputs();
        chk("data_v", 32'(data_v_o), 32'(exp_v));
        chk("rst_addr", 32'(data_rst_addr_o), 32'(exp_rst));
        chk("data", 32'(data_o), 32'(exp_data));
        chk("busy", 32'(busy_o), 32'(exp_busy));
        chk("err", 32'(err_o), 32'(exp_err));
        if (exp_v) chk("mode", 32'(data_mode_o), 32'(exp_mode));
    endtask

    // One clock: drive away from the edge, check ready, then check registered outputs
    task automatic step(input logic v, input logic e, input logic [7:0] d);
        in_valid_i = v;
        ena        = e;
        in_data_i  = d;
        #1;
        chk("in_ready", 32'(in_ready_o), 32'(e));
        model_step(v, e, d);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic hdr_byte(input logic [7:0] d);
        step(1'b1, 1'b1, d);
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic async_reset_check();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("reset_mode", 32'(data_mode_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       v, e;

        model_reset();
        #2;
        chk("por_data_v", 32'(data_v_o), 32'd0);
        chk("por_busy", 32'(busy_o), 32'd0);
        chk("por_err", 32'(err_o), 32'd0);
        chk("por_data", 32'(data_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Weight frame of 4, then oversize weight frame and RSTADDR
        tbl.push_back(mk(1, 1, 8'h43, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 8'h11, 1, 0, 1, 8'h11, 1, 0));
        tbl.push_back(mk(1, 1, 8'h22, 1, 0, 1, 8'h22, 1, 0));
        tbl.push_back(mk(1, 1, 8'h33, 1, 0, 1, 8'h33, 1, 0));
        tbl.push_back(mk(1, 1, 8'h44, 1, 0, 1, 8'h44, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 8'h44, 0, 0));
        tbl.push_back(mk(1, 1, 8'h44, 0, 0, 1, 8'h44, 1, 0));
        tbl.push_back(mk(1, 1, 8'h01, 1, 0, 1, 8'h01, 1, 0));
        tbl.push_back(mk(1, 1, 8'h02, 1, 0, 1, 8'h02, 1, 0));
        tbl.push_back(mk(1, 1, 8'h03, 1, 0, 1, 8'h03, 1, 0));
        tbl.push_back(mk(1, 1, 8'h04, 1, 0, 1, 8'h04, 1, 0));
        tbl.push_back(mk(1, 1, 8'h05, 0, 0, 1, 8'h04, 0, 1));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 8'h04, 0, 1));
        tbl.push_back(mk(1, 1, 8'h80, 1, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].e, tbl[i].d);
            chk("tbl_data_v", 32'(data_v_o), 32'(tbl[i].xv));
            chk("tbl_rst_addr", 32'(data_rst_addr_o), 32'(tbl[i].xr));
            chk("tbl_data", 32'(data_o), 32'(tbl[i].xd));
            chk("tbl_busy", 32'(busy_o), 32'(tbl[i].xb));
            chk("tbl_err", 32'(err_o), 32'(tbl[i].xe));
            if (tbl[i].xv) chk("tbl_mode", 32'(data_mode_o), 32'(tbl[i].xm));
        end

        // DATA frame with 2-cycle valid gaps
        hdr_byte(8'h01);
        idle_cycle(); idle_cycle();
        hdr_byte(8'hA5);
        idle_cycle(); idle_cycle();
        hdr_byte(8'h5A);
        idle_cycle();

        // NOP produces nothing, then a one-byte DATA frame
        hdr_byte(8'hC0);
        hdr_byte(8'h00);
        hdr_byte(8'h77);
        idle_cycle();

        // ena low mid DATA frame
        hdr_byte(8'h02);
        hdr_byte(8'h10);
        step(1'b1, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 8'hEF);
        step(1'b1, 1'b0, 8'hF0);
        hdr_byte(8'h20);
        hdr_byte(8'h30);
        idle_cycle();

        // Async reset mid WEIGHT frame, then RSTADDR header
        hdr_byte(8'h42);
        hdr_byte(8'hAA);
        async_reset_check();
        hdr_byte(8'h80);
        idle_cycle();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) != 0);
            if (!m_in_frame) begin
                d = {2'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7))};
            end else begin
                d = 8'($urandom);
            end
            step(v, e, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
